counter_bcd_display: RTL and testbench

Downstream consumer of the free-running binary `counter` stage. It periodically snapshots `counter_out` and converts it to packed BCD with a sequential shift-add-3 (double-dabble) engine. It then drives a time-multiplexed, active-low seven-segment display so the count is visible on the board.

---
 rtl/clk_counter_pkg.sv | 33 +++
 rtl/seg7_decode.sv | 29 ++
 rtl/counter_bcd_display.sv | 179 +++++++++++++++++
 tb/tb_counter_bcd_display.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_counter_pkg.sv
// rtl/clk_counter_pkg.sv - shared types and constants for the BCD display path
// Purpose: converter FSM state type, active-low seven-segment glyphs {g,f,e,d,c,b,a},
//          and the digit-index width helper used by the scanner.
// Ports:   none (package).
package clk_counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int DIGITS_DEFAULT = 10;
  localparam int DIGIT_IDX_W    = $clog2(DIGITS_DEFAULT);

  // $clog2(DIGITS), kept at least 1 bit so a single-digit display still has an index.
  function automatic int digit_idx_w(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational BCD digit to active-low seven-segment glyph
// Purpose: maps 0..9 to standard glyphs; codes 10..15 show blank.
// Ports:   bcd   (in, 4)  - BCD digit
//          seg_n (out, 7) - segments {g,f,e,d,c,b,a}, active-low
module seg7_decode
  import clk_counter_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    case (bcd)
      4'd0:    seg_n = SEG_0;
      4'd1:    seg_n = SEG_1;
      4'd2:    seg_n = SEG_2;
      4'd3:    seg_n = SEG_3;
      4'd4:    seg_n = SEG_4;
      4'd5:    seg_n = SEG_5;
      4'd6:    seg_n = SEG_6;
      4'd7:    seg_n = SEG_7;
      4'd8:    seg_n = SEG_8;
      4'd9:    seg_n = SEG_9;
      default: seg_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/counter_bcd_display.sv
// rtl/counter_bcd_display.sv - periodic binary snapshot, double-dabble BCD, muxed 7-seg
// Purpose: every REFRESH_DIV clocks snapshot counter_in, convert it to packed BCD one
//          bit per clock, latch the result, and scan it onto a multiplexed display.
// Ports:   clk        (in, 1)          - clock, all state on posedge
//          neg_reset  (in, 1)          - asynchronous active-low reset
//          counter_in (in, WIDTH)      - binary count from the upstream counter
//          bcd_out    (out, 4*DIGITS)  - last converted value, digit 0 in [3:0]
//          bcd_valid  (out, 1)         - one-cycle pulse when bcd_out updates
//          busy       (out, 1)         - conversion in progress
//          seg_n      (out, 7)         - segments {g,f,e,d,c,b,a}, active-low
//          dig_sel_n  (out, DIGITS)    - one-hot-low digit enable
module counter_bcd_display
  import clk_counter_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DIGITS      = 10,
  parameter int REFRESH_DIV = 50_000_000,
  parameter int SCAN_DIV    = 50_000
) (
  input  logic                  clk,
  input  logic                  neg_reset,
  input  logic [WIDTH-1:0]      counter_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  bcd_valid,
  output logic                  busy,
  output logic [6:0]            seg_n,
  output logic [DIGITS-1:0]     dig_sel_n
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int RW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW    = $clog2(WIDTH + 1);
  localparam int IW    = digit_idx_w(DIGITS);

  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST    = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST     = IW'(DIGITS - 1);

  // Refresh timer
  logic [RW-1:0] refresh_q, refresh_d;
  logic          sample_tick;

  // Converter
  conv_state_e      state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BCD_W-1:0] acc_q, acc_d, acc_adj;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             valid_q, valid_d;

  // Scanner
  logic [SW-1:0]     scan_q, scan_d;
  logic              scan_tick;
  logic [IW-1:0]     idx_q, idx_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] dig_q, dig_d;
  logic [3:0]        scan_digit;
  logic [6:0]        scan_glyph;

  // ---------------------------------------------------------------- refresh timer
  always_comb begin
    sample_tick = (refresh_q == REFRESH_LAST);
    refresh_d   = sample_tick ? '0 : refresh_q + RW'(1);
  end

  always_ff @(posedge clk or negedge neg_reset) begin
    if (!neg_reset) refresh_q <= '0;
    else            refresh_q <= refresh_d;
  end

  // ---------------------------------------------------------------- converter
  // Add-3 is per 4-bit digit with no carry between digits; a digit entering here
  // is at most 9, so the sum never wraps.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    acc_d    = acc_q;
    bitcnt_d = bitcnt_q;
    bcd_d    = bcd_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // A tick arriving while a conversion runs is simply ignored.
        if (sample_tick) begin
          sr_d     = counter_in;
          acc_d    = '0;
          bitcnt_d = BW'(WIDTH);
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        {acc_d, sr_d} = {acc_adj, sr_q} << 1;
        bitcnt_d      = bitcnt_q - BW'(1);
        if (bitcnt_q == BW'(1)) state_d = DONE;
      end
      DONE: begin
        bcd_d   = acc_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge neg_reset) begin
    if (!neg_reset) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      acc_q    <= '0;
      bitcnt_q <= '0;
      bcd_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      acc_q    <= acc_d;
      bitcnt_q <= bitcnt_d;
      bcd_q    <= bcd_d;
      valid_q  <= valid_d;
    end
  end

  // ---------------------------------------------------------------- scanner
  // Reads only the latched result, so the display never shows a half-converted value.
  always_comb begin
    scan_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) scan_digit = bcd_q[4*i +: 4];
    end
  end

  seg7_decode u_seg7_decode (
    .bcd   (scan_digit),
    .seg_n (scan_glyph)
  );

  always_comb begin
    scan_tick = (scan_q == SCAN_LAST);
    scan_d    = scan_tick ? '0 : scan_q + SW'(1);
    idx_d     = idx_q;
    seg_d     = seg_q;
    dig_d     = dig_q;
    if (scan_tick) begin
      dig_d = ~(DIGITS'(1) << idx_q);
      seg_d = scan_glyph;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge neg_reset) begin
    if (!neg_reset) begin
      scan_q <= '0;
      idx_q  <= '0;
      seg_q  <= SEG_BLANK;
      dig_q  <= '1;
    end else begin
      scan_q <= scan_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      dig_q  <= dig_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign bcd_out   = bcd_q;
  assign bcd_valid = valid_q;
  assign busy      = (state_q != IDLE);
  assign seg_n     = seg_q;
  assign dig_sel_n = dig_q;

endmodule

// File: tb/tb_counter_bcd_display.sv
// tb/tb_counter_bcd_display.sv - self-checking bench for counter_bcd_display
module tb_counter_bcd_display;

  localparam int WIDTH       = 32;
  localparam int DIGITS      = 10;
  localparam int REFRESH_DIV = 40;
  localparam int SCAN_DIV    = 2;
  localparam int BCD_W       = 4 * DIGITS;

  // Standard active-low glyphs {g,f,e,d,c,b,a}; 10..15 blank.
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
  };

  logic              clk = 1'b0;
  logic              neg_reset = 1'b0;
  logic              live = 1'b0;
  logic [WIDTH-1:0]  drv_val = '0;
  logic [WIDTH-1:0]  up_cnt;
  logic [WIDTH-1:0]  counter_in;
  logic [BCD_W-1:0]  bcd_out;
  logic              bcd_valid;
  logic              busy;
  logic [6:0]        seg_n;
  logic [DIGITS-1:0] dig_sel_n;

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor state (written only by the monitor process)
  int ncyc = 0;
  int busy_run = 0;
  int last_busy = 0;
  int valid_cnt = 0;
  int last_valid_cyc = 0;
  int prev_valid_cyc = 0;

  always #5 clk = ~clk;

  // Stand-in for the upstream free-running counter sharing clk/neg_reset.
  always_ff @(posedge clk or negedge neg_reset) begin
    if (!neg_reset) up_cnt <= '0;
    else            up_cnt <= up_cnt + 1'b1;
  end

  assign counter_in = live ? up_cnt : drv_val;

  counter_bcd_display #(
    .WIDTH       (WIDTH),
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .SCAN_DIV    (SCAN_DIV)
  ) dut (
    .clk        (clk),
    .neg_reset  (neg_reset),
    .counter_in (counter_in),
    .bcd_out    (bcd_out),
    .bcd_valid  (bcd_valid),
    .busy       (busy),
    .seg_n      (seg_n),
    .dig_sel_n  (dig_sel_n)
  );

  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (neg_reset !== 1'b1) begin
      busy_run = 0;
    end else begin
      if (busy === 1'b1) busy_run = busy_run + 1;
      if (bcd_valid === 1'b1) begin
        valid_cnt      = valid_cnt + 1;
        last_busy      = busy_run;
        busy_run       = 0;
        prev_valid_cyc = last_valid_cyc;
        last_valid_cyc = ncyc;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Decimal digits of v by plain division.
  function automatic logic [BCD_W-1:0] to_bcd(input longint unsigned v);
    logic [BCD_W-1:0] r;
    longint unsigned  x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int low_index(input logic [DIGITS-1:0] v);
    int idx;
    int zeros;
    idx = -1;
    zeros = 0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[i] === 1'b0) begin
        zeros++;
        idx = i;
      end
    end
    return (zeros == 1) ? idx : -1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int budget, output bit found);
    found = 1'b0;
    for (int k = 0; k < budget && !found; k++) begin
      @(negedge clk); #1;
      if (bcd_valid === 1'b1) found = 1'b1;
    end
  endtask

  // Sample n consecutive cycles; display must walk digits in order, one step per
  // SCAN_DIV cycles, and show the glyph of the expected digit.
  task automatic scan_check(input logic [BCD_W-1:0] exp_bcd, input int n);
    int idx;
    int prev_idx;
    int changes;
    int wraps;
    logic [3:0] d;
    prev_idx = -1;
    changes = 0;
    wraps = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk); #1;
      idx = low_index(dig_sel_n);
      check("scan_onehot", 64'(idx >= 0), 64'd1);
      if (idx >= 0) begin
        d = exp_bcd[4*idx +: 4];
        check("scan_glyph", 64'(seg_n), 64'(GLYPH[d]));
        if (prev_idx >= 0 && idx != prev_idx) begin
          changes++;
          check("scan_order", 64'(idx), 64'((prev_idx + 1) % DIGITS));
          if (prev_idx == DIGITS - 1 && idx == 0) wraps++;
        end
      end
      prev_idx = idx;
    end
    check("scan_rate", 64'(changes), 64'((n - 1) / SCAN_DIV));
    check("scan_wrap", 64'(wraps > 0), 64'd1);
  endtask

  initial begin
    logic [WIDTH-1:0] vals[$];
    logic [WIDTH-1:0] prev_val;
    logic [WIDTH-1:0] r;
    int  rel_cyc;
    int  vsnap;
    bit  ok;

    // ---------------- reset
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    check("rst_bcd_out", 64'(bcd_out), 64'd0);
    check("rst_bcd_valid", 64'(bcd_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_seg_n", 64'(seg_n), 64'h7F);
    check("rst_dig_sel_n", 64'(dig_sel_n), 64'h3FF);
    neg_reset = 1'b1;
    rel_cyc = ncyc;

    @(negedge clk); #1;
    check("pre_scan_seg_n", 64'(seg_n), 64'h7F);
    check("pre_scan_dig_sel_n", 64'(dig_sel_n), 64'h3FF);
    @(negedge clk); #1;
    check("first_scan_dig_sel_n", 64'(dig_sel_n), 64'h3FE);
    check("first_scan_seg_n", 64'(seg_n), 64'(GLYPH[0]));

    wait_valid(100, ok);
    check("first_valid_found", 64'(ok), 64'd1);
    check("first_valid_cycle", 64'(last_valid_cyc - rel_cyc), 64'(REFRESH_DIV + WIDTH + 1));
    check("first_busy_len", 64'(last_busy), 64'(WIDTH + 1));
    check("conv_zero", 64'(bcd_out), 64'(to_bcd(0)));

    // ---------------- directed and random conversions
    vals.push_back(32'd12345);
    vals.push_back(32'hFFFF_FFFF);
    vals.push_back(32'd999_999_999);
    vals.push_back(32'd1_000_000_000);
    for (int i = 0; i < 6; i++) vals.push_back($urandom);
    vals.push_back(32'd1_234_567_890);
    prev_val = '0;
    foreach (vals[i]) begin
      drv_val = vals[i];
      @(negedge clk); #1;
      check("valid_pulse_width", 64'(bcd_valid), 64'd0);
      check("bcd_hold", 64'(bcd_out), 64'(to_bcd(64'(prev_val))));
      scan_check(to_bcd(64'(prev_val)), 27);
      wait_valid(60, ok);
      check("valid_found", 64'(ok), 64'd1);
      check("valid_period", 64'(last_valid_cyc - prev_valid_cyc), 64'(REFRESH_DIV));
      check("busy_len", 64'(last_busy), 64'(WIDTH + 1));
      check("conv_value", 64'(bcd_out), 64'(to_bcd(64'(vals[i]))));
      check("idle_after_done", 64'(busy), 64'd0);
      prev_val = vals[i];
    end

    // ---------------- reset in the middle of a conversion
    r = $urandom;
    drv_val = r;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk); #1;
      if (busy === 1'b1) ok = 1'b1;
    end
    check("busy_rise_found", 64'(ok), 64'd1);
    repeat (9) @(negedge clk);
    #1;
    vsnap = valid_cnt;
    neg_reset = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_valid", 64'(bcd_valid), 64'd0);
    check("midrst_bcd_out", 64'(bcd_out), 64'd0);
    check("midrst_seg_n", 64'(seg_n), 64'h7F);
    check("midrst_dig_sel_n", 64'(dig_sel_n), 64'h3FF);
    repeat (3) @(negedge clk);
    #1;
    check("midrst_no_valid", 64'(valid_cnt), 64'(vsnap));
    neg_reset = 1'b1;
    rel_cyc = ncyc;
    wait_valid(100, ok);
    check("postrst_valid_found", 64'(ok), 64'd1);
    check("postrst_valid_cycle", 64'(last_valid_cyc - rel_cyc), 64'(REFRESH_DIV + WIDTH + 1));
    check("postrst_conv", 64'(bcd_out), 64'(to_bcd(64'(r))));

    // ---------------- live chain from the upstream counter
    live = 1'b1;
    neg_reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    neg_reset = 1'b1;
    rel_cyc = ncyc;
    for (int k = 1; k <= 4; k++) begin
      wait_valid(100, ok);
      check("live_valid_found", 64'(ok), 64'd1);
      check("live_valid_cycle", 64'(last_valid_cyc - rel_cyc),
            64'(REFRESH_DIV + WIDTH + 1 + REFRESH_DIV * (k - 1)));
      check("live_conv", 64'(bcd_out), 64'(to_bcd(64'(REFRESH_DIV * k - 1))));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
